// File: rtl/vend_ctrl_multi.sv
// Multi-item vending controller: per-item prices, configurable coin values, change, cancel/refund, coin rejection.
// Optional idle auto-refund is enabled by defining VEND_TIMEOUT_EN.
module vend_ctrl_multi #(
  parameter int                              CREDIT_W       = 8,
  parameter int                              NUM_ITEMS      = 4,
  parameter int                              SEL_W          = 2,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0]   ITEM_PRICE     = {8'd7, 8'd5, 8'd3, 8'd2},
  parameter int                              COIN1_VAL      = 1,
  parameter int                              COIN2_VAL      = 2,
  parameter int                              COIN3_VAL      = 5,
  parameter int                              TIMEOUT_CYCLES = 1000
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [1:0]          in,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel,
  input  logic                cancel,
  output logic                out,
  output logic [SEL_W-1:0]    out_item,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, REFUND} state_t;

  state_t             state;
  logic               sel_held;
  logic [SEL_W-1:0]   held_sel;

  logic [CREDIT_W-1:0] price_tbl [NUM_ITEMS];
  logic [CREDIT_W-1:0] price;
  logic [CREDIT_W:0]   coin_val;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_present;
  logic                coin_fits;
  logic                sel_ok;
  logic                vend_ok;
  logic                active;
  logic                abort;
  logic                coin_taken;
  logic                sel_taken;
  logic                timeout_hit;

  if (NUM_ITEMS < 2 || SEL_W != $clog2(NUM_ITEMS) || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("vend_ctrl_multi: inconsistent NUM_ITEMS/SEL_W/TIMEOUT_CYCLES");
  end

  for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_price
    assign price_tbl[i] = ITEM_PRICE[i*CREDIT_W +: CREDIT_W];
  end

  // Overflow is detected in the extra carry bit of the widened sum.
  always_comb begin
    coin_val = '0;
    case (in)
      2'd1:    coin_val = (CREDIT_W+1)'(COIN1_VAL);
      2'd2:    coin_val = (CREDIT_W+1)'(COIN2_VAL);
      2'd3:    coin_val = (CREDIT_W+1)'(COIN3_VAL);
      default: coin_val = '0;
    endcase
    price        = price_tbl[held_sel];
    coin_present = (in != 2'd0);
    coin_sum     = {1'b0, credit} + coin_val;
    coin_fits    = !coin_sum[CREDIT_W];
    sel_ok       = sel_valid && (int'(sel) < NUM_ITEMS);
    vend_ok      = sel_held && (credit >= price);
    active       = (state == IDLE) || (state == COLLECT);
    abort        = cancel || timeout_hit;
    coin_taken   = active && !abort && !vend_ok && coin_present && coin_fits;
    sel_taken    = active && !abort && !vend_ok && sel_ok;
  end

`ifdef VEND_TIMEOUT_EN
  logic [31:0] idle_cnt;

  // Counts quiet COLLECT cycles; a rejected coin is not activity.
  always_ff @(posedge CLK) begin
    if (RST) begin
      idle_cnt <= '0;
    end else if (state != COLLECT || coin_taken || sel_taken) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end

  assign timeout_hit = (state == COLLECT) && (idle_cnt >= 32'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      credit       <= '0;
      sel_held     <= 1'b0;
      held_sel     <= '0;
      out          <= 1'b0;
      out_item     <= '0;
      change_valid <= 1'b0;
      change       <= '0;
      coin_reject  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      out          <= 1'b0;
      change_valid <= 1'b0;
      coin_reject  <= 1'b0;
      busy         <= 1'b0;
      case (state)
        IDLE, COLLECT: begin
          if (abort) begin
            coin_reject <= coin_present;
            if (credit != '0 || sel_held) begin
              state        <= REFUND;
              busy         <= 1'b1;
              change_valid <= 1'b1;
              change       <= credit;
              credit       <= '0;
              sel_held     <= 1'b0;
            end
          end else if (vend_ok) begin
            // Vend decision uses registered credit/selection; inputs on this edge are not merged in.
            coin_reject  <= coin_present;
            state        <= VEND;
            busy         <= 1'b1;
            out          <= 1'b1;
            out_item     <= held_sel;
            change_valid <= 1'b1;
            change       <= credit - price;
            credit       <= '0;
            sel_held     <= 1'b0;
          end else begin
            if (coin_taken) begin
              credit <= coin_sum[CREDIT_W-1:0];
            end
            coin_reject <= coin_present && !coin_fits;
            if (sel_taken) begin
              sel_held <= 1'b1;
              held_sel <= sel;
            end
            state <= (credit != '0 || coin_taken || sel_held || sel_taken) ? COLLECT : IDLE;
          end
        end
        default: begin
          coin_reject <= coin_present;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Directed self-checking bench for vend_ctrl_multi (default prices 2/3/5/7, coins 1/2/5).
// Timeout scenario follows VEND_TIMEOUT_EN when defined.
module tb_vend_ctrl_multi;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] coin;
  logic       sel_valid;
  logic [1:0] sel;
  logic       cancel;
  logic       out;
  logic [1:0] out_item;
  logic       change_valid;
  logic [7:0] change;
  logic [7:0] credit;
  logic       coin_reject;
  logic       busy;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  vend_ctrl_multi #(.TIMEOUT_CYCLES(20)) dut (
    .CLK(CLK), .RST(RST), .in(coin), .sel_valid(sel_valid), .sel(sel), .cancel(cancel),
    .out(out), .out_item(out_item), .change_valid(change_valid), .change(change),
    .credit(credit), .coin_reject(coin_reject), .busy(busy)
  );

  // Presents one cycle of inputs, then samples just after the edge.
  task automatic step(input logic [1:0] c, input logic sv, input logic [1:0] s, input logic cn);
    coin = c; sel_valid = sv; sel = s; cancel = cn;
    @(posedge CLK);
    #1;
    coin = 2'd0; sel_valid = 1'b0; cancel = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    step(2'd0, 1'b0, 2'd0, 1'b0);
    step(2'd0, 1'b0, 2'd0, 1'b0);
    RST = 1'b0;
    checks++; if (out !== 1'b0) begin failures++; $display("[TB] FAIL reset_out: got %b expected 0", out); end
    checks++; if (change_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_change_valid: got %b expected 0", change_valid); end
    checks++; if (credit !== 8'd0) begin failures++; $display("[TB] FAIL reset_credit: got %0d expected 0", credit); end
    checks++; if (change !== 8'd0) begin failures++; $display("[TB] FAIL reset_change: got %0d expected 0", change); end
    checks++; if ({coin_reject, busy, out_item} !== 4'b0) begin failures++; $display("[TB] FAIL reset_misc: got %b expected 0000", {coin_reject, busy, out_item}); end
  endtask

  task automatic test_vend_exact();
    step(2'd0, 1'b1, 2'd3, 1'b0);
    step(2'd3, 1'b0, 2'd0, 1'b0);
    checks++; if (credit !== 8'd5) begin failures++; $display("[TB] FAIL exact_credit5: got %0d expected 5", credit); end
    step(2'd2, 1'b0, 2'd0, 1'b0);
    checks++; if (credit !== 8'd7 || out !== 1'b0) begin failures++; $display("[TB] FAIL exact_credit7: got credit=%0d out=%b expected 7/0", credit, out); end
    step(2'd0, 1'b0, 2'd0, 1'b0);
    checks++; if (out !== 1'b1 || out_item !== 2'd3) begin failures++; $display("[TB] FAIL exact_vend: got out=%b item=%0d expected 1/3", out, out_item); end
    checks++; if (change_valid !== 1'b1 || change !== 8'd0) begin failures++; $display("[TB] FAIL exact_change: got cv=%b change=%0d expected 1/0", change_valid, change); end
    checks++; if (credit !== 8'd0 || busy !== 1'b1) begin failures++; $display("[TB] FAIL exact_after: got credit=%0d busy=%b expected 0/1", credit, busy); end
    step(2'd0, 1'b0, 2'd0, 1'b0);
    checks++; if (out !== 1'b0 || busy !== 1'b0 || change_valid !== 1'b0) begin failures++; $display("[TB] FAIL exact_pulse_end: got out=%b busy=%b cv=%b expected 0/0/0", out, busy, change_valid); end
  endtask

  task automatic test_vend_change();
    step(2'd3, 1'b1, 2'd1, 1'b0);
    checks++; if (credit !== 8'd5 || out !== 1'b0) begin failures++; $display("[TB] FAIL change_collect: got credit=%0d out=%b expected 5/0", credit, out); end
    step(2'd0, 1'b0, 2'd0, 1'b0);
    checks++; if (out !== 1'b1 || out_item !== 2'd1 || change !== 8'd2 || change_valid !== 1'b1) begin failures++; $display("[TB] FAIL change_vend: got out=%b item=%0d change=%0d cv=%b expected 1/1/2/1", out, out_item, change, change_valid); end
    step(2'd0, 1'b0, 2'd0, 1'b0);
    checks++; if (change !== 8'd2 || out_item !== 2'd1 || change_valid !== 1'b0) begin failures++; $display("[TB] FAIL change_hold: got change=%0d item=%0d cv=%b expected 2/1/0", change, out_item, change_valid); end
  endtask

  task automatic test_sel_after_credit();
    step(2'd2, 1'b0, 2'd0, 1'b0);
    step(2'd2, 1'b0, 2'd0, 1'b0);
    step(2'd0, 1'b1, 2'd1, 1'b0);
    checks++; if (out !== 1'b0 || credit !== 8'd4) begin failures++; $display("[TB] FAIL late_sel_latch: got out=%b credit=%0d expected 0/4", out, credit); end
    step(2'd0, 1'b0, 2'd0, 1'b0);
    checks++; if (out !== 1'b1 || out_item !== 2'd1 || change !== 8'd1) begin failures++; $display("[TB] FAIL late_sel_vend: got out=%b item=%0d change=%0d expected 1/1/1", out, out_item, change); end
    step(2'd0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic test_cancel();
    step(2'd2, 1'b0, 2'd0, 1'b0);
    step(2'd2, 1'b0, 2'd0, 1'b0);
    step(2'd0, 1'b0, 2'd0, 1'b1);
    checks++; if (change_valid !== 1'b1 || change !== 8'd4) begin failures++; $display("[TB] FAIL cancel_refund: got cv=%b change=%0d expected 1/4", change_valid, change); end
    checks++; if (out !== 1'b0 || credit !== 8'd0 || busy !== 1'b1) begin failures++; $display("[TB] FAIL cancel_state: got out=%b credit=%0d busy=%b expected 0/0/1", out, credit, busy); end
    step(2'd0, 1'b0, 2'd0, 1'b0);
    checks++; if (busy !== 1'b0 || change_valid !== 1'b0) begin failures++; $display("[TB] FAIL cancel_idle: got busy=%b cv=%b expected 0/0", busy, change_valid); end
    step(2'd1, 1'b0, 2'd0, 1'b1);
    checks++; if (coin_reject !== 1'b1 || change_valid !== 1'b0 || credit !== 8'd0) begin failures++; $display("[TB] FAIL cancel_empty: got rej=%b cv=%b credit=%0d expected 1/0/0", coin_reject, change_valid, credit); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 51; i++) step(2'd3, 1'b0, 2'd0, 1'b0);
    checks++; if (credit !== 8'd255 || coin_reject !== 1'b0) begin failures++; $display("[TB] FAIL ovf_fill: got credit=%0d rej=%b expected 255/0", credit, coin_reject); end
    step(2'd3, 1'b0, 2'd0, 1'b0);
    checks++; if (coin_reject !== 1'b1 || credit !== 8'd255) begin failures++; $display("[TB] FAIL ovf_reject: got rej=%b credit=%0d expected 1/255", coin_reject, credit); end
    step(2'd1, 1'b0, 2'd0, 1'b0);
    checks++; if (coin_reject !== 1'b1 || credit !== 8'd255) begin failures++; $display("[TB] FAIL ovf_reject1: got rej=%b credit=%0d expected 1/255", coin_reject, credit); end
    step(2'd0, 1'b0, 2'd0, 1'b1);
    checks++; if (change_valid !== 1'b1 || change !== 8'd255 || credit !== 8'd0) begin failures++; $display("[TB] FAIL ovf_cancel: got cv=%b change=%0d credit=%0d expected 1/255/0", change_valid, change, credit); end
    step(2'd0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic test_cancel_with_coin();
    step(2'd2, 1'b0, 2'd0, 1'b0);
    step(2'd1, 1'b0, 2'd0, 1'b1);
    checks++; if (coin_reject !== 1'b1 || change_valid !== 1'b1 || change !== 8'd2) begin failures++; $display("[TB] FAIL cancel_coin: got rej=%b cv=%b change=%0d expected 1/1/2", coin_reject, change_valid, change); end
    checks++; if (credit !== 8'd0) begin failures++; $display("[TB] FAIL cancel_coin_credit: got %0d expected 0", credit); end
    step(2'd0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic test_back_to_back_coins();
    step(2'd2, 1'b1, 2'd0, 1'b0);
    step(2'd1, 1'b0, 2'd0, 1'b0);
    checks++; if (out !== 1'b1 || coin_reject !== 1'b1 || change !== 8'd0) begin failures++; $display("[TB] FAIL vend_edge_coin: got out=%b rej=%b change=%0d expected 1/1/0", out, coin_reject, change); end
    step(2'd1, 1'b0, 2'd0, 1'b0);
    checks++; if (coin_reject !== 1'b1 || credit !== 8'd0 || out !== 1'b0) begin failures++; $display("[TB] FAIL vend_cycle_coin: got rej=%b credit=%0d out=%b expected 1/0/0", coin_reject, credit, out); end
    step(2'd0, 1'b0, 2'd0, 1'b0);
    checks++; if (credit !== 8'd0 || coin_reject !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL vend_cycle_after: got credit=%0d rej=%b busy=%b expected 0/0/0", credit, coin_reject, busy); end
  endtask

  task automatic test_reset_mid();
    step(2'd0, 1'b1, 2'd3, 1'b0);
    step(2'd1, 1'b0, 2'd0, 1'b0);
    step(2'd2, 1'b0, 2'd0, 1'b0);
    checks++; if (credit !== 8'd3) begin failures++; $display("[TB] FAIL mid_credit: got %0d expected 3", credit); end
    RST = 1'b1;
    step(2'd0, 1'b0, 2'd0, 1'b0);
    RST = 1'b0;
    checks++; if (credit !== 8'd0 || change_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset: got credit=%0d cv=%b expected 0/0", credit, change_valid); end
    step(2'd3, 1'b0, 2'd0, 1'b0);
    step(2'd2, 1'b0, 2'd0, 1'b0);
    step(2'd0, 1'b0, 2'd0, 1'b0);
    checks++; if (out !== 1'b0 || credit !== 8'd7 || change_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_sel_cleared: got out=%b credit=%0d cv=%b expected 0/7/0", out, credit, change_valid); end
    step(2'd0, 1'b0, 2'd0, 1'b1);
    checks++; if (change !== 8'd7 || change_valid !== 1'b1) begin failures++; $display("[TB] FAIL mid_cleanup: got change=%0d cv=%b expected 7/1", change, change_valid); end
    step(2'd0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    step(2'd1, 1'b0, 2'd0, 1'b0);
`ifdef VEND_TIMEOUT_EN
    for (int i = 1; i < 20; i++) begin
      step(2'd0, 1'b0, 2'd0, 1'b0);
      if (change_valid === 1'b1) early++;
    end
    checks++; if (early !== 0) begin failures++; $display("[TB] FAIL timeout_early: got %0d early pulses expected 0", early); end
    step(2'd0, 1'b0, 2'd0, 1'b0);
    checks++; if (change_valid !== 1'b1 || change !== 8'd1 || credit !== 8'd0) begin failures++; $display("[TB] FAIL timeout_refund: got cv=%b change=%0d credit=%0d expected 1/1/0", change_valid, change, credit); end
    step(2'd0, 1'b0, 2'd0, 1'b0);
`else
    for (int i = 0; i < 100; i++) begin
      step(2'd0, 1'b0, 2'd0, 1'b0);
      if (change_valid === 1'b1) early++;
    end
    checks++; if (early !== 0) begin failures++; $display("[TB] FAIL hold_no_refund: got %0d refund pulses expected 0", early); end
    checks++; if (credit !== 8'd1) begin failures++; $display("[TB] FAIL hold_credit: got %0d expected 1", credit); end
    step(2'd0, 1'b0, 2'd0, 1'b1);
    checks++; if (change_valid !== 1'b1 || change !== 8'd1) begin failures++; $display("[TB] FAIL hold_cancel: got cv=%b change=%0d expected 1/1", change_valid, change); end
    step(2'd0, 1'b0, 2'd0, 1'b0);
`endif
  endtask

  initial begin
    RST = 1'b1; coin = 2'd0; sel_valid = 1'b0; sel = 2'd0; cancel = 1'b0;
    test_reset();
    test_vend_exact();
    test_vend_change();
    test_sel_after_credit();
    test_cancel();
    test_overflow();
    test_cancel_with_coin();
    test_back_to_back_coins();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
